// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants for the instruction memory
package imem_pkg;

    localparam int          DEFAULT_DEPTH = 1280;
    localparam int          WORD_SHIFT    = 2;
    localparam logic [31:0] FAULT_INSTR   = 32'h0000_0000;

endpackage

// File: rtl/imem_ram_1r1w.sv
// rtl/imem_ram_1r1w.sv - word storage with one synchronous read and one synchronous write port
module imem_ram_1r1w #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1280,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; rdata only changes on a read strobe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_sync.sv
// rtl/imem_sync.sv - instruction fetch memory with valid/ready handshake, fault check and fetch counter
module imem_sync
    import imem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_fault,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [31:0]       fetch_count
);

    localparam int                RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

    logic [ADDR_W-1:0] req_index;
    logic [ADDR_W-1:0] ld_index;
    logic              req_bad;
    logic              ld_ok;
    logic              ld_fire;
    logic              accept;
    logic              rd_en;
    logic [DATA_W-1:0] ram_rdata;

    assign req_index = req_addr >> WORD_SHIFT;
    assign ld_index  = ld_addr >> WORD_SHIFT;

    assign req_bad = (req_addr[WORD_SHIFT-1:0] != '0) || (req_index >= DEPTH_LIM);
    assign ld_ok   = (ld_addr[WORD_SHIFT-1:0] == '0) && (ld_index < DEPTH_LIM);
    assign ld_fire = rst_n && ld_en && ld_ok;

    assign req_ready = rst_n && !ld_en && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rd_en     = accept && !req_bad;

    imem_ram_1r1w #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ld_fire),
        .waddr (ld_index[RAM_AW-1:0]),
        .wdata (ld_data),
        .re    (rd_en),
        .raddr (req_index[RAM_AW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_fault   <= 1'b0;
            fetch_count <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_fault <= req_bad;
            if (fetch_count != 32'hFFFF_FFFF) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // RAM output is masked so idle, reset and faulted responses read as zero.
    assign rsp_instr = (rsp_valid && !rsp_fault) ? ram_rdata : DATA_W'(FAULT_INSTR);

endmodule

// File: tb/tb_imem_sync.sv
// tb/tb_imem_sync.sv - directed self-checking bench for imem_sync
module tb_imem_sync;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1280;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic              rsp_fault;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [31:0]       fetch_count;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_mem [4];
    logic [31:0] exp_cnt;

    imem_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_instr   (rsp_instr),
        .rsp_fault   (rsp_fault),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    initial begin
        exp_mem[0] = 32'h00002083;
        exp_mem[1] = 32'h00102103;
        exp_mem[2] = 32'h00202183;
        exp_mem[3] = 32'h00302203;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        step(); step();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_fault", 64'(rsp_fault), 64'd0);
        chk("rst_rsp_instr", 64'(rsp_instr), 64'd0);
        chk("rst_fetch_count", 64'(fetch_count), 64'd0);
        req_valid = 1'b1; #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;

        // Preload and back-to-back fetch of words 0..3
        for (int i = 0; i < 4; i++) load(32'(4 * i), exp_mem[i]);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_addr = 32'(4 * i); #1;
            chk("b2b_req_ready", 64'(req_ready), 64'd1);
            step();
            chk("b2b_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("b2b_rsp_instr", 64'(rsp_instr), 64'(exp_mem[i]));
        end
        req_valid = 1'b0;
        step();
        chk("b2b_idle_valid", 64'(rsp_valid), 64'd0);
        chk("b2b_count", 64'(fetch_count), 64'd4);
        exp_cnt = 32'd4;

        // Backpressure: response held three cycles, then released
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd4;
        step(); exp_cnt++;
        req_addr = 32'd8;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rsp_instr", 64'(rsp_instr), 64'(exp_mem[1]));
            step();
        end
        rsp_ready = 1'b1; #1;
        chk("release_req_ready", 64'(req_ready), 64'd1);
        step(); exp_cnt++;
        chk("release_next_instr", 64'(rsp_instr), 64'(exp_mem[2]));
        req_valid = 1'b0;
        step();
        chk("release_idle", 64'(rsp_valid), 64'd0);
        chk("hold_count", 64'(fetch_count), 64'(exp_cnt));

        // Faults: misaligned and out of range
        req_valid = 1'b1; req_addr = 32'd6;
        step(); exp_cnt++;
        chk("mis_fault", 64'(rsp_fault), 64'd1);
        chk("mis_instr", 64'(rsp_instr), 64'd0);
        req_addr = 32'(4 * DEPTH);
        step(); exp_cnt++;
        chk("oor_valid", 64'(rsp_valid), 64'd1);
        chk("oor_fault", 64'(rsp_fault), 64'd1);
        chk("oor_instr", 64'(rsp_instr), 64'd0);
        req_valid = 1'b0;
        step();
        chk("fault_count", 64'(fetch_count), 64'(exp_cnt));
        load(32'(4 * DEPTH), 32'hDEADBEEF);
        load(32'd2, 32'hCAFEF00D);
        #1;
        chk("bad_load_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_addr = 32'd0;
        step(); exp_cnt++;
        req_valid = 1'b0;
        chk("bad_load_dropped", 64'(rsp_instr), 64'(exp_mem[0]));
        chk("ok_after_fault", 64'(rsp_fault), 64'd0);
        step();

        // Load blocks fetch; fetch follows with the new data
        exp_mem[3] = 32'h00402283;
        ld_en = 1'b1; ld_addr = 32'd12; ld_data = exp_mem[3];
        req_valid = 1'b1; req_addr = 32'd12; #1;
        chk("load_blocks_ready", 64'(req_ready), 64'd0);
        step();
        chk("load_no_count", 64'(fetch_count), 64'(exp_cnt));
        ld_en = 1'b0; #1;
        chk("after_load_ready", 64'(req_ready), 64'd1);
        step(); exp_cnt++;
        req_valid = 1'b0;
        chk("after_load_instr", 64'(rsp_instr), 64'(exp_mem[3]));
        step();

        // Held response keeps captured data across a later load of the same word
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd8;
        step(); exp_cnt++;
        req_valid = 1'b0;
        load(32'd8, 32'h00502303);
        chk("held_vs_load", 64'(rsp_instr), 64'(exp_mem[2]));
        exp_mem[2] = 32'h00502303;
        rsp_ready = 1'b1;
        step();
        chk("held_vs_load_idle", 64'(rsp_valid), 64'd0);
        chk("count_before_rst", 64'(fetch_count), 64'(exp_cnt));

        // Reset with a held response and fetch_count = 5
        rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = 32'(4 * (i % 4));
            step();
        end
        req_valid = 1'b0; rsp_ready = 1'b0; #1;
        chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
        chk("pre_rst_count", 64'(fetch_count), 64'd5);
        chk("pre_rst_instr", 64'(rsp_instr), 64'(exp_mem[0]));
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_count", 64'(fetch_count), 64'd0);
        chk("mid_rst_instr", 64'(rsp_instr), 64'd0);
        rst_n = 1'b1; rsp_ready = 1'b1;
        step();
        chk("no_replay", 64'(rsp_valid), 64'd0);
        req_valid = 1'b1; req_addr = 32'd0;
        step();
        req_valid = 1'b0;
        chk("refetch_valid", 64'(rsp_valid), 64'd1);
        chk("refetch_instr", 64'(rsp_instr), 64'(exp_mem[0]));
        chk("refetch_count", 64'(fetch_count), 64'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_sync.md
IMEM_SYNC -- requirements
Module: imem_sync

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width of fetch and load ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 SHALL have parameter DEPTH, default 1280, meaning number of words stored.
REQ-004 SHALL have port clk, input, 1, meaning single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-006 SHALL have port req_valid, input, 1, meaning fetch request present.
REQ-007 SHALL have port req_ready, output, 1, meaning fetch request accepted this cycle.
REQ-008 SHALL have port req_addr, input, ADDR_W, meaning fetch byte address (PC).
REQ-009 SHALL have port rsp_valid, output, 1, meaning response held on rsp_instr and rsp_fault.
REQ-010 SHALL have port rsp_ready, input, 1, meaning consumer takes the response.
REQ-011 SHALL have port rsp_instr, output, DATA_W, meaning fetched word.
REQ-012 SHALL have port rsp_fault, output, 1, meaning request was misaligned or out of range.
REQ-013 SHALL have port ld_en, input, 1, meaning program-load write strobe.
REQ-014 SHALL have port ld_addr, input, ADDR_W, meaning load byte address.
REQ-015 SHALL have port ld_data, input, DATA_W, meaning load word.
REQ-016 SHALL have port fetch_count, output, 32, meaning accepted-fetch counter, saturating.

Function
REQ-017 SHALL compute word index as addr>>2 for both ports, so PC+4 advances one word.
REQ-018 SHALL assert req_ready = !ld_en && (!rsp_valid || rsp_ready); fetches stall while a load is in progress.
REQ-019 SHALL capture a request on req_valid && req_ready and present rsp_valid the next cycle (latency 1).
REQ-020 SHALL hold rsp_valid, rsp_instr and rsp_fault stable while rsp_valid && !rsp_ready.
REQ-021 SHALL clear rsp_valid on rsp_ready when no new request is accepted in the same cycle, and keep it set when a request is accepted in that cycle (back-to-back, one per cycle).
REQ-022 SHALL flag a fault when req_addr[1:0] != 0 or the word index >= DEPTH; on fault rsp_fault=1 and rsp_instr=0.
REQ-023 SHALL write ld_data to the word on ld_en when ld_addr[1:0]==0 and the index < DEPTH; other loads are silently dropped.
REQ-024 SHALL not overlap loads and fetches, since REQ-018 blocks acceptance; a response already held SHALL keep its captured data even if the same word is loaded afterwards.
REQ-025 SHALL increment fetch_count on each accepted request, faults included, and saturate at 32'hFFFFFFFF.
REQ-026 SHALL treat memory contents as undefined until loaded; the bench SHALL preload every word it fetches.

Reset
REQ-027 SHALL, on rst_n=0 at a clock edge, set rsp_valid=0, rsp_fault=0, rsp_instr=0 and fetch_count=0.
REQ-028 SHALL drop a pending or held response when reset occurs mid-operation, with no replay.
REQ-029 SHALL hold req_ready=0 during reset and ignore ld_en during reset.
REQ-030 SHALL not clear memory contents on reset.

Structure
REQ-031 SHALL place DEFAULT_DEPTH, WORD_SHIFT (2) and FAULT_INSTR (0) in shared package imem_pkg.
REQ-032 SHALL put storage in sub-module imem_ram_1r1w (one sync read port, one sync write port, parametrised DATA_W/DEPTH); imem_sync holds the handshake, fault check and counter.

Verification
REQ-033 SHALL cover: load words 0..3 = 32'h00002083, 32'h00102103, 32'h00202183, 32'h00302203; fetch 0,4,8,12 with rsp_ready=1 -> same words on 4 consecutive cycles, fetch_count=4.
REQ-034 SHALL cover: fetch addr 4 with rsp_ready=0 for 3 cycles -> rsp_instr held at 32'h00102103, req_ready=0, then released on rsp_ready=1.
REQ-035 SHALL cover: fetch addr 6, and fetch addr 4*DEPTH -> rsp_fault=1, rsp_instr=0; load to 4*DEPTH -> no write, no hang.
REQ-036 SHALL cover: ld_en=1 with req_valid=1 -> req_ready=0; fetch proceeds the cycle after ld_en drops and returns the new data.
REQ-037 SHALL cover: rst_n=0 while rsp_valid=1 and fetch_count=5 -> next cycle rsp_valid=0, fetch_count=0; refetch of addr 0 returns the preloaded word.
